// File: rtl/mnist_pkg.sv
// Shared types and helpers for the MNIST fully-connected layer engine.
package mnist_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int BIAS_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        DRAIN,
        EMIT,
        DONE
    } state_t;

    function automatic logic signed [ACC_W_DEF-1:0] relu(input logic signed [ACC_W_DEF-1:0] x);
        return x[ACC_W_DEF-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/mnist_mac_unit.sv
// Multiply-accumulate datapath: loads the bias, then adds pixel*weight products.
module mnist_mac_unit #(
    parameter int DATA_W = 8,
    parameter int BIAS_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_bias,
    input  logic                     acc_en,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic        [DATA_W-1:0] pixel,
    input  logic signed [DATA_W-1:0] weight,
    output logic signed [ACC_W-1:0]  acc
);

    // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
    logic signed [2*DATA_W:0] prod;

    assign prod = $signed({1'b0, pixel}) * weight;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else if (load_bias) begin
            acc <= {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
        end else if (acc_en) begin
            acc <= acc + {{(ACC_W-2*DATA_W-1){prod[2*DATA_W]}}, prod};
        end
    end

endmodule

// File: rtl/mnist_dense_layer.sv
// Dense layer engine: per-neuron bias + dot product, ReLU, streamed results and argmax.
module mnist_dense_layer
    import mnist_pkg::*;
#(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 10,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BIAS_W = BIAS_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int WW    = $clog2(N_IN*N_OUT)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IW-1:0]     in_addr,
    input  logic [DATA_W-1:0] in_rdata,
    output logic [WW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_rdata,
    output logic [OW-1:0]     b_addr,
    input  logic [BIAS_W-1:0] b_rdata,
    output logic              out_valid,
    output logic [OW-1:0]     out_idx,
    output logic [ACC_W-1:0]  out_value,
    output logic [OW-1:0]     class_idx,
    output logic              class_valid
);

    localparam logic [IW-1:0] J_LAST = IW'(N_IN-1);
    localparam logic [OW-1:0] N_LAST = OW'(N_OUT-1);

    state_t state, state_nx;

    logic        [IW-1:0]    j;
    logic        [OW-1:0]    n;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_relu;
    logic signed [ACC_W-1:0] best;
    logic        [OW-1:0]    best_idx;
    logic        [WW-1:0]    w_addr_c;
    logic        [IW-1:0]    in_addr_q;
    logic        [WW-1:0]    w_addr_q;
    logic        [OW-1:0]    b_addr_q;
    logic        [OW-1:0]    out_idx_q;
    logic        [ACC_W-1:0] out_value_q;
    logic                    class_valid_q;
    logic                    load_bias;
    logic                    acc_en;

    assign acc_relu = relu(acc);
    assign w_addr_c = WW'(n) * WW'(N_IN) + WW'(j);

    // Bias arrives with MAC j=0; each later MAC cycle and DRAIN add the previous request's product.
    assign load_bias = (state == MAC) && (j == '0);
    assign acc_en    = ((state == MAC) && (j != '0)) || (state == DRAIN);

    mnist_mac_unit #(
        .DATA_W (DATA_W),
        .BIAS_W (BIAS_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clock     (ACLK),
        .reset     (ARESET),
        .load_bias (load_bias),
        .acc_en    (acc_en),
        .bias      ($signed(b_rdata)),
        .pixel     (in_rdata),
        .weight    ($signed(w_rdata)),
        .acc       (acc)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = MAC;
            MAC:     if (j == J_LAST) state_nx = DRAIN;
            DRAIN:   state_nx = EMIT;
            EMIT:    state_nx = (n == N_LAST) ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counters, held address/result registers and the running argmax (ties keep the lower index).
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            j             <= '0;
            n             <= '0;
            best          <= '0;
            best_idx      <= '0;
            in_addr_q     <= '0;
            w_addr_q      <= '0;
            b_addr_q      <= '0;
            out_idx_q     <= '0;
            out_value_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n             <= '0;
                        best          <= '0;
                        best_idx      <= '0;
                        class_valid_q <= 1'b0;
                    end
                end
                LOAD: begin
                    j        <= '0;
                    b_addr_q <= n;
                end
                MAC: begin
                    in_addr_q <= j;
                    w_addr_q  <= w_addr_c;
                    j         <= j + IW'(1);
                end
                EMIT: begin
                    out_idx_q   <= n;
                    out_value_q <= acc_relu;
                    if ((n == '0) || (acc_relu > best)) begin
                        best     <= acc_relu;
                        best_idx <= n;
                    end
                    if (n != N_LAST) begin
                        n <= n + OW'(1);
                    end
                end
                DONE: class_valid_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign out_valid   = (state == EMIT);
    assign in_addr     = (state == MAC)  ? j        : in_addr_q;
    assign w_addr      = (state == MAC)  ? w_addr_c : w_addr_q;
    assign b_addr      = (state == LOAD) ? n        : b_addr_q;
    assign out_idx     = (state == EMIT) ? n        : out_idx_q;
    assign out_value   = (state == EMIT) ? acc_relu : out_value_q;
    assign class_idx   = best_idx;
    assign class_valid = class_valid_q | done;

endmodule

// File: tb/tb_mnist_dense_layer.sv
// Self-checking bench for mnist_dense_layer: small 4x3 instance plus a full-width 784-input instance.
module tb_mnist_dense_layer;

    localparam int SN_IN     = 4;
    localparam int SN_OUT    = 3;
    localparam int BN_IN     = 784;
    localparam int BN_OUT    = 2;
    localparam int RUN_LIMIT = 100;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic start = 1'b0;
    logic big_start = 1'b0;

    always #5 ACLK = ~ACLK;

    // Small instance signals and memories
    logic        busy, done, out_valid, class_valid;
    logic [1:0]  in_addr, b_addr, out_idx, class_idx;
    logic [3:0]  w_addr;
    logic [31:0] out_value;
    logic [7:0]  in_rdata = '0, w_rdata = '0;
    logic [15:0] b_rdata = '0;

    logic [7:0]        pix [4];
    logic signed [7:0] wt  [16];
    logic signed [15:0] bs [4];

    always @(posedge ACLK) begin
        in_rdata <= pix[in_addr];
        w_rdata  <= wt[w_addr];
        b_rdata  <= bs[b_addr];
    end

    mnist_dense_layer #(.N_IN(SN_IN), .N_OUT(SN_OUT)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .in_rdata(in_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata), .out_valid(out_valid), .out_idx(out_idx),
        .out_value(out_value), .class_idx(class_idx), .class_valid(class_valid)
    );

    // Full-width instance: all pixels 255, neuron 0 weights -128, neuron 1 weights 127, biases 0
    logic        big_busy, big_done, big_out_valid, big_class_valid;
    logic [9:0]  big_in_addr;
    logic [10:0] big_w_addr;
    logic [0:0]  big_b_addr, big_out_idx, big_class_idx;
    logic [31:0] big_out_value;
    logic [7:0]  big_in_rdata = '0, big_w_rdata = '0;
    logic [15:0] big_b_rdata = '0;

    always @(posedge ACLK) begin
        big_in_rdata <= 8'd255;
        big_w_rdata  <= (big_w_addr >= 11'(BN_IN)) ? 8'sd127 : -8'sd128;
        big_b_rdata  <= '0;
    end

    mnist_dense_layer #(.N_IN(BN_IN), .N_OUT(BN_OUT)) dut_big (
        .ACLK(ACLK), .ARESET(ARESET), .start(big_start), .busy(big_busy), .done(big_done),
        .in_addr(big_in_addr), .in_rdata(big_in_rdata), .w_addr(big_w_addr), .w_rdata(big_w_rdata),
        .b_addr(big_b_addr), .b_rdata(big_b_rdata), .out_valid(big_out_valid), .out_idx(big_out_idx),
        .out_value(big_out_value), .class_idx(big_class_idx), .class_valid(big_class_valid)
    );

    int errors = 0;
    int checks = 0;

    // Observations from the last run
    int   n_valid, done_cnt, done_cyc, done_class, post_busy, post_cv, timed_out;
    int   v_idx [8];
    int   v_cyc [8];
    logic [31:0] v_val [8];

    // Reference results
    int exp_val [SN_OUT];
    int exp_class;

    task automatic check(input string tag, input logic signed [63:0] observed,
                         input logic signed [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Dot product + ReLU per neuron and a first-wins argmax, straight from the arithmetic definition.
    task automatic compute_expected();
        int best;
        best = 0;
        exp_class = 0;
        for (int nn = 0; nn < SN_OUT; nn++) begin
            int a;
            a = int'(bs[nn]);
            for (int jj = 0; jj < SN_IN; jj++)
                a += int'(pix[jj]) * int'(wt[nn*SN_IN + jj]);
            exp_val[nn] = (a < 0) ? 0 : a;
            if (nn == 0 || exp_val[nn] > best) begin
                best = exp_val[nn];
                exp_class = nn;
            end
        end
    endtask

    task automatic apply_reset(input int cycles);
        ARESET = 1'b1;
        repeat (cycles) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
    endtask

    task automatic run_small(input int pulse_mac, input bit pulse_done, input int abort_at);
        int cyc;
        bit stop;
        n_valid = 0; done_cnt = 0; done_cyc = -1; done_class = -1; post_busy = 0;
        start = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
        cyc = 1;
        stop = 1'b0;
        while (!stop && cyc < RUN_LIMIT) begin
            if (out_valid) begin
                if (n_valid < 8) begin
                    v_idx[n_valid] = int'(out_idx);
                    v_val[n_valid] = out_value;
                    v_cyc[n_valid] = cyc;
                end
                n_valid++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_class = int'(class_idx);
                stop = 1'b1;
                if (pulse_done) start = 1'b1;
            end
            if (cyc == abort_at) begin
                ARESET = 1'b1;
                stop = 1'b1;
            end
            if (cyc == pulse_mac) start = 1'b1;
            @(posedge ACLK); #1;
            start = 1'b0;
            ARESET = 1'b0;
            cyc++;
        end
        timed_out = stop ? 0 : 1;
        post_cv = int'(class_valid);
        for (int k = 0; k < 4; k++) begin
            if (done) done_cnt++;
            if (busy) post_busy++;
            @(posedge ACLK); #1;
        end
    endtask

    task automatic check_run(input string tag);
        check({tag, "_timeout"}, timed_out, 0);
        check({tag, "_nvalid"}, n_valid, SN_OUT);
        for (int k = 0; k < SN_OUT; k++) begin
            check($sformatf("%s_idx%0d", tag, k), v_idx[k], k);
            check($sformatf("%s_val%0d", tag, k), v_val[k], exp_val[k]);
            check($sformatf("%s_cyc%0d", tag, k), v_cyc[k], (k+1)*(SN_IN+3));
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cyc"}, done_cyc, SN_OUT*(SN_IN+3)+1);
        check({tag, "_class"}, done_class, exp_class);
        check({tag, "_class_valid"}, post_cv, 1);
        check({tag, "_idle_busy"}, post_busy, 0);
    endtask

    task automatic load_scenario2();
        logic signed [7:0] w2 [12];
        w2 = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd5};
        for (int k = 0; k < 4; k++) pix[k] = 8'(k + 1);
        for (int k = 0; k < 12; k++) wt[k] = w2[k];
        bs[0] = 16'sd0; bs[1] = 16'sd0; bs[2] = 16'sd2;
    endtask

    initial begin
        int cyc;
        int b_nvalid, b_done_cyc, b_class, b_v1_cyc;
        logic [31:0] b_val [2];

        for (int k = 0; k < 16; k++) wt[k] = '0;
        for (int k = 0; k < 4; k++) begin pix[k] = '0; bs[k] = '0; end

        // Reset state
        apply_reset(5);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_addrs", {in_addr, w_addr, b_addr}, 0);
        check("rst_class", {class_idx, class_valid}, 0);

        // Hand-computed example
        load_scenario2();
        compute_expected();
        run_small(0, 1'b0, 0);
        check_run("s2");
        check("s2_const_val0", v_val[0], 10);
        check("s2_const_val1", v_val[1], 0);
        check("s2_const_val2", v_val[2], 22);
        check("s2_const_class", done_class, 2);

        // Reset after a completed run
        apply_reset(5);
        check("rst2_class_valid", class_valid, 0);
        check("rst2_busy", busy, 0);
        check("rst2_out_value", out_value, 0);

        // All-equal outputs: tie keeps index 0
        for (int k = 0; k < 16; k++) wt[k] = '0;
        for (int k = 0; k < 3; k++) bs[k] = 16'sd5;
        compute_expected();
        run_small(0, 1'b0, 0);
        check_run("tie");
        check("tie_const_class", done_class, 0);

        // start pulses inside MAC and DONE are ignored
        load_scenario2();
        compute_expected();
        run_small(3, 1'b1, 0);
        check_run("restart");

        // Reset during MAC of neuron 1 aborts with no done
        run_small(0, 1'b0, 10);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_busy", post_busy, 0);
        check("abort_class_valid", post_cv, 0);
        run_small(0, 1'b0, 0);
        check_run("after_abort");

        // Randomised images, weights and biases
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) pix[k] = 8'($urandom);
            for (int k = 0; k < 12; k++) wt[k] = 8'($urandom);
            for (int k = 0; k < 3; k++) bs[k] = 16'($urandom);
            compute_expected();
            run_small(0, 1'b0, 0);
            check_run($sformatf("rand%0d", r));
        end

        // Full-width extremes: accumulator must not wrap
        b_nvalid = 0; b_done_cyc = -1; b_class = -1; b_v1_cyc = -1;
        b_val[0] = 'x; b_val[1] = 'x;
        big_start = 1'b1;
        @(posedge ACLK); #1;
        big_start = 1'b0;
        cyc = 1;
        while (b_done_cyc < 0 && cyc < 2000) begin
            if (big_out_valid) begin
                if (b_nvalid < 2) b_val[b_nvalid] = big_out_value;
                if (b_nvalid == 1) b_v1_cyc = cyc;
                b_nvalid++;
            end
            if (big_done) begin
                b_done_cyc = cyc;
                b_class = int'(big_class_idx);
            end
            @(posedge ACLK); #1;
            cyc++;
        end
        check("big_nvalid", b_nvalid, 2);
        check("big_neg_relu", b_val[0], 0);
        check("big_pos_nowrap", b_val[1], 25389840);
        check("big_v1_cyc", b_v1_cyc, 2*(BN_IN+3));
        check("big_done_cyc", b_done_cyc, BN_OUT*(BN_IN+3)+1);
        check("big_class", b_class, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
